// File: rtl/signal_event_tracker_pkg.sv
// Shared types and constants for the pipeline-phase signal trackers.
// Time values are signed cycle numbers; -1 marks "no time".
package signal_event_tracker_pkg;

    typedef logic signed [31:0] stime_t;

    localparam stime_t TIME_NONE = -32'sd1;

    typedef struct packed {
        stime_t time_start;
        stime_t time_end;
    } interval_t;

    typedef struct packed {
        interval_t phase;
        interval_t mem_access_req;
        interval_t mem_access_res;
        logic      pass_through;
    } trace_output_t;

    typedef struct packed {
        stime_t t_start;
        stime_t t_end;
        logic   valid;
    } event_entry_t;

    function automatic stime_t smax(input stime_t a, input stime_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic stime_t smin(input stime_t a, input stime_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/signal_event_tracker_event_ring.sv
// Circular store of high intervals; a rise opens a new entry at the
// write pointer, a fall closes the newest one. Full ring overwrites oldest.
module signal_event_tracker_event_ring
    import signal_event_tracker_pkg::*;
#(
    parameter int SIZE = 128
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rise_i,
    input  logic                      fall_i,
    input  stime_t                    counter_i,
    output event_entry_t              entries_o [SIZE],
    output logic [$clog2(SIZE)-1:0]   wptr_o
);

    localparam int AW = $clog2(SIZE);

    event_entry_t  entries_q [SIZE];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] wptr_d;
    logic [AW-1:0] newest;

    assign newest = wptr_q - AW'(1);
    assign wptr_d = rise_i ? wptr_q + AW'(1) : wptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            if (rise_i) begin
                entries_q[wptr_q] <= '{t_start: counter_i,
                                       t_end:   TIME_NONE,
                                       valid:   1'b1};
            end else if (fall_i) begin
                entries_q[newest].t_end <= counter_i - 32'sd1;
            end
        end
    end

    assign entries_o = entries_q;
    assign wptr_o    = wptr_q;

endmodule

// File: rtl/trace_buffer.sv
// First-word fall-through FIFO carrying trace records between trackers.
// Pushes while full are dropped; pops while empty are ignored.
module trace_buffer
    import signal_event_tracker_pkg::*;
#(
    parameter int  SIZE = 32,
    parameter type T    = trace_output_t
)(
    input  logic clk,
    input  logic rst,
    input  logic ready_signal,
    input  T     trace_element_in,
    input  logic data_request,
    output T     trace_element_out,
    output logic data_present
);

    localparam int AW = $clog2(SIZE);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(SIZE);

    T              mem_q [SIZE];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          push;
    logic          pop;

    assign push = ready_signal && (cnt_q != FULL_CNT);
    assign pop  = data_request && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= trace_element_in;
    end

    assign trace_element_out = mem_q[rd_q];
    assign data_present      = (cnt_q != '0);

endmodule

// File: rtl/signal_event_tracker.sv
// Records high intervals of one handshake signal and answers
// look-back interval and single-cycle queries against that history.
module signal_event_tracker
    import signal_event_tracker_pkg::*;
#(
    parameter int SIGNAL_WIDTH = 1,
    parameter int BUFFER_SIZE  = 128
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [31:0]      counter,
    input  logic [SIGNAL_WIDTH-1:0] tracked_signal,
    input  logic signed [31:0]      value_in,
    input  logic                    recalculate_time,
    output logic signed [31:0]      time_out [1:0],
    input  logic signed [31:0]      range_in [0:1],
    input  logic                    recalculate_single_cycle,
    output logic signed [31:0]      single_cycle_out,
    input  logic signed [31:0]      previous_end_i,
    input  logic                    update_end,
    input  logic                    previous_end_memory,
    input  logic                    ready_flag,
    input  logic                    ex_ready_flag,
    input  logic                    data_mem_req_flag
);

    localparam int AW = $clog2(BUFFER_SIZE);

    event_entry_t  ring [BUFFER_SIZE];
    logic [AW-1:0] wptr;
    logic          sig_now;
    logic          prev_q;
    stime_t        last_end_q;
    stime_t        ts_q;
    stime_t        te_q;
    stime_t        sc_q;
    stime_t        ts_d;
    stime_t        te_d;
    stime_t        sc_d;

    assign sig_now = |tracked_signal;

    signal_event_tracker_event_ring #(
        .SIZE      (BUFFER_SIZE)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .rise_i    (sig_now && !prev_q),
        .fall_i    (!sig_now && prev_q),
        .counter_i (counter),
        .entries_o (ring),
        .wptr_o    (wptr)
    );

    // Walk from the oldest slot so the first hit is the oldest entry.
    always_comb begin
        event_entry_t e;
        stime_t       low;
        logic         found;
        logic         ok;
        e     = '0;
        ok    = 1'b0;
        found = 1'b0;
        ts_d  = TIME_NONE;
        te_d  = TIME_NONE;
        low   = counter - value_in;
        for (int k = 0; k < BUFFER_SIZE; k++) begin
            e  = ring[wptr + AW'(k)];
            ok = e.valid && (e.t_start >= low) &&
                 ((e.t_start > last_end_q) ||
                  ((e.t_start == last_end_q) &&
                   previous_end_memory && ready_flag));
            if (ok && !found) begin
                found = 1'b1;
                ts_d  = e.t_start;
                if (e.t_end != TIME_NONE) begin
                    te_d = e.t_end;
                end else if (ex_ready_flag) begin
                    te_d = counter - 32'sd1;
                end
            end
        end
    end

    // Clip each interval to the range; open ones extend to counter-1.
    always_comb begin
        event_entry_t e;
        stime_t       eff_end;
        stime_t       lo;
        stime_t       hi;
        e       = '0;
        eff_end = TIME_NONE;
        lo      = TIME_NONE;
        hi      = TIME_NONE;
        sc_d    = TIME_NONE;
        for (int k = 0; k < BUFFER_SIZE; k++) begin
            e       = ring[k];
            eff_end = (e.t_end == TIME_NONE) ? counter - 32'sd1 : e.t_end;
            lo      = smax(e.t_start, range_in[0]);
            hi      = smin(eff_end, range_in[1]);
            if (e.valid && (range_in[0] <= range_in[1]) && (lo <= hi)) begin
                if (data_mem_req_flag) begin
                    if (sc_d == TIME_NONE || hi > sc_d) sc_d = hi;
                end else begin
                    if (sc_d == TIME_NONE || lo < sc_d) sc_d = lo;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= 1'b0;
            last_end_q <= '0;
            ts_q       <= TIME_NONE;
            te_q       <= TIME_NONE;
            sc_q       <= TIME_NONE;
        end else begin
            prev_q <= sig_now;
            if (update_end) last_end_q <= previous_end_i;
            if (recalculate_time) begin
                ts_q <= ts_d;
                te_q <= te_d;
            end
            if (recalculate_single_cycle) sc_q <= sc_d;
        end
    end

    assign time_out[0]      = recalculate_time ? ts_d : ts_q;
    assign time_out[1]      = recalculate_time ? te_d : te_q;
    assign single_cycle_out = recalculate_single_cycle ? sc_d : sc_q;

endmodule

// File: tb/tb_signal_event_tracker.sv
// Directed bench for signal_event_tracker and trace_buffer.
// Expected values are hand-derived from the recorded high cycles.
module tb_signal_event_tracker;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] counter;
    logic [0:0]         tracked_signal;
    logic signed [31:0] value_in;
    logic               recalculate_time;
    logic signed [31:0] time_out [1:0];
    logic signed [31:0] range_in [0:1];
    logic               recalculate_single_cycle;
    logic signed [31:0] single_cycle_out;
    logic signed [31:0] previous_end_i;
    logic               update_end;
    logic               previous_end_memory;
    logic               ready_flag;
    logic               ex_ready_flag;
    logic               data_mem_req_flag;

    logic               b_push;
    logic [7:0]         b_in;
    logic               b_pop;
    logic [7:0]         b_out;
    logic               b_present;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    signal_event_tracker #(
        .SIGNAL_WIDTH             (1),
        .BUFFER_SIZE              (128)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .counter                  (counter),
        .tracked_signal           (tracked_signal),
        .value_in                 (value_in),
        .recalculate_time         (recalculate_time),
        .time_out                 (time_out),
        .range_in                 (range_in),
        .recalculate_single_cycle (recalculate_single_cycle),
        .single_cycle_out         (single_cycle_out),
        .previous_end_i           (previous_end_i),
        .update_end               (update_end),
        .previous_end_memory      (previous_end_memory),
        .ready_flag               (ready_flag),
        .ex_ready_flag            (ex_ready_flag),
        .data_mem_req_flag        (data_mem_req_flag)
    );

    trace_buffer #(
        .SIZE              (32),
        .T                 (logic [7:0])
    ) u_buf (
        .clk               (clk),
        .rst               (rst),
        .ready_signal      (b_push),
        .trace_element_in  (b_in),
        .data_request      (b_pop),
        .trace_element_out (b_out),
        .data_present      (b_present)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s);
        tracked_signal = s;
        @(posedge clk);
        #1 counter = counter + 1;
    endtask

    task automatic do_reset();
        rst                      = 1'b1;
        counter                  = 0;
        tracked_signal           = 1'b0;
        value_in                 = 0;
        recalculate_time         = 1'b0;
        range_in[0]              = 0;
        range_in[1]              = 0;
        recalculate_single_cycle = 1'b0;
        previous_end_i           = 0;
        update_end               = 1'b0;
        previous_end_memory      = 1'b0;
        ready_flag               = 1'b0;
        ex_ready_flag            = 1'b0;
        data_mem_req_flag        = 1'b0;
        b_push                   = 1'b0;
        b_in                     = 8'h00;
        b_pop                    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic bclk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_t0", time_out[0], -1);
        check("rst_t1", time_out[1], -1);
        check("rst_sc", single_cycle_out, -1);

        // High cycles 10..12, query at counter 20, look back 15.
        for (int c = 0; c < 20; c++) tick(c >= 10 && c <= 12);
        value_in = 15;
        recalculate_time = 1'b1;
        #1;
        check("iv_comb_s", time_out[0], 10);
        check("iv_comb_e", time_out[1], 12);
        tick(1'b0);
        recalculate_time = 1'b0;
        value_in = 1;
        #1;
        check("iv_hold_s", time_out[0], 10);
        check("iv_hold_e", time_out[1], 12);

        // Open interval from 18.
        do_reset();
        for (int c = 0; c < 20; c++) tick(c >= 18);
        value_in = 5;
        recalculate_time = 1'b1;
        #1;
        check("open_s", time_out[0], 18);
        check("open_e", time_out[1], -1);
        ex_ready_flag = 1'b1;
        #1;
        check("exr_s", time_out[0], 18);
        check("exr_e", time_out[1], 19);
        recalculate_time = 1'b0;
        ex_ready_flag = 1'b0;

        // Intervals 5-6 and 9-9 with last_end gating.
        do_reset();
        for (int c = 0; c < 12; c++) tick(c == 5 || c == 6 || c == 9);
        previous_end_i = 6;
        update_end = 1'b1;
        tick(1'b0);
        update_end = 1'b0;
        value_in = counter - 3;
        recalculate_time = 1'b1;
        #1;
        check("le6_s", time_out[0], 9);
        check("le6_e", time_out[1], 9);
        recalculate_time = 1'b0;
        previous_end_i = 9;
        update_end = 1'b1;
        tick(1'b0);
        update_end = 1'b0;
        value_in = counter - 3;
        previous_end_memory = 1'b1;
        ready_flag = 1'b1;
        recalculate_time = 1'b1;
        #1;
        check("le9m_s", time_out[0], 9);
        check("le9m_e", time_out[1], 9);
        previous_end_memory = 1'b0;
        #1;
        check("le9_s", time_out[0], -1);
        check("le9_e", time_out[1], -1);
        recalculate_time = 1'b0;
        ready_flag = 1'b0;

        // Single high cycles 7 and 11.
        do_reset();
        for (int c = 0; c < 14; c++) tick(c == 7 || c == 11);
        recalculate_single_cycle = 1'b1;
        range_in[0] = 8;
        range_in[1] = 12;
        #1;
        check("sc_8_12", single_cycle_out, 11);
        range_in[0] = 12;
        range_in[1] = 15;
        #1;
        check("sc_12_15", single_cycle_out, -1);
        range_in[0] = 6;
        range_in[1] = 12;
        #1;
        check("sc_6_12", single_cycle_out, 7);
        data_mem_req_flag = 1'b1;
        #1;
        check("sc_last", single_cycle_out, 11);
        data_mem_req_flag = 1'b0;
        range_in[0] = 12;
        range_in[1] = 8;
        #1;
        check("sc_inv", single_cycle_out, -1);
        range_in[0] = 8;
        range_in[1] = 12;
        value_in = 14;
        recalculate_time = 1'b1;
        #1;
        check("both_s", time_out[0], 7);
        check("both_sc", single_cycle_out, 11);
        recalculate_time = 1'b0;
        recalculate_single_cycle = 1'b0;

        // 130 one-cycle pulses at 1,3,...,259 into 128 slots.
        do_reset();
        for (int c = 0; c < 260; c++) tick(c[0]);
        value_in = counter;
        recalculate_time = 1'b1;
        recalculate_single_cycle = 1'b1;
        range_in[0] = 0;
        range_in[1] = 4;
        #1;
        check("wrap_s", time_out[0], 5);
        check("wrap_e", time_out[1], 5);
        check("wrap_sc_lost", single_cycle_out, -1);
        range_in[1] = 6;
        #1;
        check("wrap_sc", single_cycle_out, 5);
        rst = 1'b1;
        #1;
        check("midrst_t0", time_out[0], -1);
        check("midrst_t1", time_out[1], -1);
        check("midrst_sc", single_cycle_out, -1);
        recalculate_time = 1'b0;
        recalculate_single_cycle = 1'b0;

        // trace_buffer FIFO behaviour.
        do_reset();
        check("buf_empty", b_present, 0);
        b_push = 1'b1;
        b_in = 8'hA1;
        bclk();
        b_in = 8'hB2;
        bclk();
        b_push = 1'b0;
        check("buf_headA", b_out, 8'hA1);
        b_pop = 1'b1;
        bclk();
        b_pop = 1'b0;
        check("buf_pres1", b_present, 1);
        check("buf_headB", b_out, 8'hB2);
        b_pop = 1'b1;
        bclk();
        b_pop = 1'b0;
        check("buf_pres0", b_present, 0);
        b_push = 1'b1;
        for (int i = 0; i < 33; i++) begin
            b_in = 8'(i);
            bclk();
        end
        b_push = 1'b0;
        check("buf_full_head", b_out, 0);
        b_pop = 1'b1;
        for (int i = 0; i < 31; i++) bclk();
        b_pop = 1'b0;
        check("buf_last", b_out, 31);
        check("buf_last_pres", b_present, 1);
        b_pop = 1'b1;
        bclk();
        b_pop = 1'b0;
        check("buf_drop33", b_present, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
